// File: rtl/pc_unit_p.sv
// Program-counter unit: next-PC selection (seq/branch/jump/register jump),
// stall hold, misaligned-target exception redirect and a circular return-address stack.
module pc_unit_p #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instruction,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic             zero,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_miss,
  output logic             addr_err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] imm_ext, br_target, j_target, ras_top;
  logic             taken, misaligned, do_push, do_pop, wr_en;
  logic [PW-1:0]    wr_idx;

  assign pc_plus4   = pc_q + WIDTH'(4);
  assign imm_ext    = {{(WIDTH-16){instruction[15]}}, instruction[15:0]};
  assign br_target  = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00};
  assign j_target   = {pc_plus4[WIDTH-1:28], instruction[25:0], 2'b00};
  assign taken      = branch & (zero ^ branch_ne);
  assign misaligned = reg_target[1:0] != 2'b00;
  assign do_push    = link & ~stall;
  assign do_pop     = ret & jump_reg & ~stall;
  assign ras_empty  = cnt_q == '0;
  assign ras_full   = cnt_q == CW'(RAS_DEPTH);
  assign ras_top    = ras_mem[top_q];

  always_comb begin
    pc_d   = pc_plus4;
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (stall)                        pc_d = pc_q;
    else if (jump_reg && misaligned)  pc_d = EXC_PC;
    else if (jump_reg)                pc_d = reg_target;
    else if (jump)                    pc_d = j_target;
    else if (taken)                   pc_d = br_target;

    // jalr-as-return replaces the top in place; on an empty stack it degrades to a push.
    if (do_push && do_pop && !ras_empty) begin
      wr_en = 1'b1;
    end else if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = top_q + PW'(1);
      top_d  = top_q + PW'(1);
      if (!ras_full) cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !ras_empty) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end

    miss_d = do_pop & (ras_empty | (ras_top != reg_target));
    err_d  = jump_reg & misaligned & ~stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RST_PC;
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) ras_mem[wr_idx] <= pc_plus4;
  end

  assign addr     = pc_q;
  assign ras_miss = miss_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_pc_unit_p.sv
// Directed bench for pc_unit_p: a cycle-by-cycle vector table plus hand sequences
// for stall, RAS overflow/underflow, reset override and a 64-bit build.
module tb_pc_unit_p;

  logic        clk = 1'b0;
  logic        reset, stall, branch, branch_ne, zero, jump, jump_reg, link, ret;
  logic [31:0] instruction, reg_target, addr, pc_plus4;
  logic        ras_empty, ras_full, ras_miss, addr_err;
  logic [63:0] reg_target64, addr64, pc_plus4_64;
  logic        ras_empty64, ras_full64, ras_miss64, addr_err64;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign reg_target64 = 64'(reg_target);

  pc_unit_p #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .instruction(instruction),
    .branch(branch), .branch_ne(branch_ne), .zero(zero), .jump(jump),
    .jump_reg(jump_reg), .reg_target(reg_target), .link(link), .ret(ret),
    .addr(addr), .pc_plus4(pc_plus4), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_miss(ras_miss), .addr_err(addr_err)
  );

  pc_unit_p #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .stall(stall), .instruction(instruction),
    .branch(branch), .branch_ne(branch_ne), .zero(zero), .jump(jump),
    .jump_reg(jump_reg), .reg_target(reg_target64), .link(link), .ret(ret),
    .addr(addr64), .pc_plus4(pc_plus4_64), .ras_empty(ras_empty64), .ras_full(ras_full64),
    .ras_miss(ras_miss64), .addr_err(addr_err64)
  );

  typedef struct {
    logic        rst, stl;
    logic [31:0] ins;
    logic        br, bne, z, j, jr;
    logic [31:0] rt;
    logic        lk, rtn;
    logic [63:0] ea;
    logic        mi, er, em, fu;
  } vec_t;

  function automatic vec_t v(input logic rst, stl, input logic [31:0] ins,
                             input logic br, bne, z, j, jr, input logic [31:0] rt,
                             input logic lk, rtn, input logic [63:0] ea,
                             input logic mi, er, em, fu);
    vec_t t;
    t.rst = rst; t.stl = stl; t.ins = ins; t.br = br; t.bne = bne; t.z = z;
    t.j = j; t.jr = jr; t.rt = rt; t.lk = lk; t.rtn = rtn;
    t.ea = ea; t.mi = mi; t.er = er; t.em = em; t.fu = fu;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input bit is64, input string tag);
    reset = t.rst; stall = t.stl; instruction = t.ins; branch = t.br;
    branch_ne = t.bne; zero = t.z; jump = t.j; jump_reg = t.jr;
    reg_target = t.rt; link = t.lk; ret = t.rtn;
    @(posedge clk);
    #1;
    if (is64) begin
      chk({tag, ".addr64"}, addr64, t.ea);
      chk({tag, ".pc_plus4_64"}, pc_plus4_64, t.ea + 64'd4);
      chk({tag, ".err64"}, 64'(addr_err64), 64'(t.er));
    end else begin
      chk({tag, ".addr"}, 64'(addr), t.ea);
      chk({tag, ".pc_plus4"}, 64'(pc_plus4), 64'(t.ea[31:0] + 32'd4));
      chk({tag, ".ras_miss"}, 64'(ras_miss), 64'(t.mi));
      chk({tag, ".addr_err"}, 64'(addr_err), 64'(t.er));
      chk({tag, ".ras_empty"}, 64'(ras_empty), 64'(t.em));
      chk({tag, ".ras_full"}, 64'(ras_full), 64'(t.fu));
    end
    $display("%s: addr=%h miss=%b err=%b empty=%b full=%b", tag,
             is64 ? addr64 : 64'(addr), is64 ? ras_miss64 : ras_miss,
             is64 ? addr_err64 : addr_err, ras_empty, ras_full);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t seq[$];

    //                 rst stl ins           br bne z j jr rt            lk rt  ea            mi er em fu
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 64'h0,        0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 64'h4,        0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 64'h8,        0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 64'hC,        0, 0, 1, 0));
    tbl.push_back(v(1, 0, 32'h10,       0, 0, 0, 1, 0, 32'h0,        0, 0, 64'h0,        0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h100,      0, 0, 64'h100,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'hFFFF,     1, 0, 1, 0, 0, 32'h0,        0, 0, 64'h100,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'hFFFF,     1, 1, 1, 0, 0, 32'h0,        0, 0, 64'h104,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h100,      0, 0, 64'h100,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h3,        1, 0, 0, 0, 0, 32'h0,        0, 0, 64'h104,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h3,        1, 1, 0, 0, 0, 32'h0,        0, 0, 64'h114,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h1000_0040, 0, 0, 64'h1000_0040, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h10,       0, 0, 0, 1, 0, 32'h0,        0, 0, 64'h1000_0040, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h200,      0, 0, 64'h200,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'hC0,       0, 0, 0, 1, 0, 32'h0,        1, 0, 64'h300,      0, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h204,      0, 1, 64'h204,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h208,      0, 1, 64'h208,      1, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 64'h20C,      0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h302,      0, 0, 64'h8000_0180, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 64'h8000_0184, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 32'h80,       0, 0, 0, 1, 0, 32'h0,        1, 0, 64'h8000_0200, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h8000_0189, 0, 1, 64'h8000_0180, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h100,      1, 1, 64'h100,      1, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h8000_0184, 1, 1, 64'h8000_0184, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h104,      0, 1, 64'h104,      0, 0, 1, 0));
    foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Stall holds PC and RAS; misaligned jump_reg under stall must not flag.
    apply(v(0, 0, 32'h0,  0, 0, 0, 0, 1, 32'h1000_0040, 0, 0, 64'h1000_0040, 0, 0, 1, 0), 1'b0, "stall0");
    apply(v(0, 1, 32'h20, 0, 0, 0, 1, 0, 32'h0,   0, 0, 64'h1000_0040, 0, 0, 1, 0), 1'b0, "stall1");
    apply(v(0, 1, 32'h20, 0, 0, 0, 1, 0, 32'h0,   0, 0, 64'h1000_0040, 0, 0, 1, 0), 1'b0, "stall2");
    apply(v(0, 1, 32'h0,  0, 0, 0, 0, 1, 32'h302, 1, 1, 64'h1000_0040, 0, 0, 1, 0), 1'b0, "stall3");
    apply(v(0, 0, 32'h20, 0, 0, 0, 1, 0, 32'h0,   0, 0, 64'h1000_0080, 0, 0, 1, 0), 1'b0, "stall_rel");

    // Overflow: five pushes into a 4-deep stack, then five pops.
    apply(v(1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 64'h0,   0, 0, 1, 0), 1'b0, "ovf_rst");
    apply(v(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 64'h400, 0, 0, 1, 0), 1'b0, "ovf_go");
    for (int k = 0; k < 5; k++)
      apply(v(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 64'(32'h404 + 32'(4 * k)),
              0, 0, 0, (k >= 3) ? 1'b1 : 1'b0), 1'b0, $sformatf("push%0d", k));
    for (int k = 0; k < 4; k++)
      apply(v(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h414 - 32'(4 * k), 0, 1,
              64'(32'h414 - 32'(4 * k)), 0, 0, (k == 3) ? 1'b1 : 1'b0, 0), 1'b0, $sformatf("pop%0d", k));
    apply(v(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h404, 0, 1, 64'h404, 1, 0, 1, 0), 1'b0, "pop4");
    apply(v(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 64'h408, 0, 0, 1, 0), 1'b0, "pop_idle");

    // Reset overrides stall, link and ret at the same edge.
    apply(v(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 64'h40C, 0, 0, 0, 0), 1'b0, "rst_pre");
    apply(v(1, 1, 32'h0, 0, 0, 0, 0, 1, 32'h40C, 1, 1, 64'h0,   0, 0, 1, 0), 1'b0, "rst_ovr");

    // 64-bit build: carry out of bit 31 and upper bits kept by branch/jump.
    seq.push_back(v(1, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0,         0, 0, 64'h0,             0, 0, 1, 0));
    seq.push_back(v(0, 0, 32'h0,    0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 64'hFFFF_FFFC,     0, 0, 1, 0));
    seq.push_back(v(0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0,         0, 0, 64'h1_0000_0000,   0, 0, 1, 0));
    seq.push_back(v(0, 0, 32'hFFFF, 1, 0, 1, 0, 0, 32'h0,         0, 0, 64'h1_0000_0000,   0, 0, 1, 0));
    seq.push_back(v(0, 0, 32'h10,   0, 0, 0, 1, 0, 32'h0,         0, 0, 64'h1_0000_0040,   0, 0, 1, 0));
    seq.push_back(v(0, 0, 32'h3,    1, 1, 0, 0, 0, 32'h0,         0, 0, 64'h1_0000_0050,   0, 0, 1, 0));
    foreach (seq[i]) apply(seq[i], 1'b1, $sformatf("w64_%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit_p.md
# pc_unit_p

Parametrised program-counter unit for the single-cycle MIPS datapath.
- Holds the PC register and computes next-PC from sequential, conditional-branch (beq/bne), direct-jump and register-jump sources.
- Adds pipeline-ready stall, an exception redirect for misaligned register targets, and a circular return-address stack (RAS) that checks `jr $ra` targets.
- Sits between instruction memory (drives `addr`) and the control unit/register file (supplies `branch`, `jump`, `reg_target`).

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits; legal range 32..64.
- `RESET_VECTOR`, 32'h0000_0000 (zero-extended to WIDTH): PC value after reset.
- `EXC_VECTOR`, 32'h8000_0180 (zero-extended to WIDTH): PC loaded on misaligned register-jump target.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, 2..16.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and RAS this cycle.
- `instruction`  in  32  current instruction word.
- `branch`  in  1  conditional branch instruction.
- `branch_ne`  in  1  0 = beq sense, 1 = bne sense.
- `zero`  in  1  ALU zero flag.
- `jump`  in  1  direct jump (j/jal).
- `jump_reg`  in  1  register jump (jr/jalr).
- `reg_target`  in  WIDTH  register-jump target from register file.
- `link`  in  1  instruction writes a return address (jal/jalr); push to RAS.
- `ret`  in  1  register jump is a return (jr $ra); pop RAS.
- `addr`  out  WIDTH  current PC (registered).
- `pc_plus4`  out  WIDTH  addr + 4, combinational; link value for the register file.
- `ras_empty`  out  1  RAS occupancy == 0.
- `ras_full`  out  1  RAS occupancy == RAS_DEPTH.
- `ras_miss`  out  1  registered one-cycle pulse: return target differed from RAS top, or RAS was empty.
- `addr_err`  out  1  registered one-cycle pulse: misaligned register target redirected.

## Operation
- `taken = branch & (zero ^ branch_ne)`.
- `br_target = pc_plus4 + (sign-extend(instruction[15:0]) << 2)`, all in WIDTH bits; wrap modulo 2^WIDTH.
- `j_target = {pc_plus4[WIDTH-1:28], instruction[25:0], 2'b00}`.
- Next-PC priority, highest first:
  - `reset` → RESET_VECTOR.
  - `stall` → hold.
  - `jump_reg` with `reg_target[1:0] != 0` → EXC_VECTOR.
  - `jump_reg` → reg_target.
  - `jump` → j_target.
  - `taken` → br_target.
  - otherwise → pc_plus4.
- `jump` and `jump_reg` both high is illegal. `jump_reg` wins; the bench never drives it.
- RAS is a circular buffer with a top pointer and a saturating count 0..RAS_DEPTH.
  - Push, when `link` is high and not stalled: write pc_plus4 at top+1 and advance top. If full, the oldest entry is overwritten and count stays at RAS_DEPTH.
  - Pop, when `ret & jump_reg` is high and not stalled: compare the top entry with reg_target.
    - `ras_miss` = 1 if empty or unequal.
    - If not empty, retreat top and decrement count. Popping while empty leaves count at 0.
  - Pop and push in the same cycle (jalr used as return): the top entry is replaced by pc_plus4 and count is unchanged. If the stack was empty, it is a plain push (count becomes 1). `ras_miss` is still evaluated.
  - A misaligned return still pops and compares. `addr_err` and `ras_miss` may both pulse.
- `ras_miss` is advisory only. Next-PC always uses reg_target.

## Timing
- Single cycle. Every next-PC decision is captured at the rising edge where its inputs are valid; `addr` shows it the following cycle.
- `pc_plus4` has zero latency from `addr`.
- `ras_miss` and `addr_err` are registered in the same edge as the redirected `addr`, high for exactly one cycle. They clear the next cycle unless the condition occurs again.
- During a stall, `ras_miss` and `addr_err` are 0 and RAS contents and pointers are unchanged.
- Reset values:
  - `addr` = RESET_VECTOR.
  - RAS count 0, top pointer 0.
  - `ras_empty` = 1, `ras_full` = 0.
  - `ras_miss` = 0, `addr_err` = 0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation, including during a stall or together with `link`/`ret`, overrides everything at that edge.
- `ras_empty` and `ras_full` are decoded from the registered count.

## Test plan
- Reset, then 3 idle cycles → addr 0x0, 0x4, 0x8, 0xC. Assert reset with jump=1 → next addr 0x0, ras_empty=1.
- At addr 0x100, branch=1, zero=1, imm=0xFFFF → addr 0x100. Same with branch_ne=1 → 0x104. beq with imm=0x0003, zero=0 → 0x104.
- At addr 0x1000_0040, jump=1, instruction[25:0]=0x000_0010 → addr 0x1000_0040. Assert stall for 2 cycles with jump held → addr unchanged, then it updates.
- jal at 0x200 (push 0x204), then jr $ra with reg_target=0x204 → addr 0x204, ras_miss=0, ras_empty=1. Repeat the return with reg_target=0x208 → ras_miss=1 for one cycle.
- Push 5 times with RAS_DEPTH=4 → ras_full=1, count 4. Five pops → the first four return the newest four addresses, the fifth gives ras_miss=1, and ras_empty=1 throughout the fifth.
- jump_reg with reg_target=0x302 → addr EXC_VECTOR and addr_err=1 for one cycle. WIDTH=64 build repeats the branch and jump cases with upper-bit carry: 0x0000_0000_FFFF_FFFC + 4 → 0x1_0000_0000.
